// File: rtl/sid_env_mul_scheduler.sv
// rtl/sid_env_mul_scheduler.sv - one shared 8x8 shift-and-add multiplier scaling every SID voice by its envelope
module sid_env_mul_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int SW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_VOICES*8-1:0] wave_in,
  input  logic [NUM_VOICES*8-1:0] env_in,
  input  logic [NUM_VOICES-1:0]   voice_en,
  output logic [NUM_VOICES*8-1:0] voice_out,
  output logic [NUM_VOICES-1:0]   out_valid,
  output logic                    busy,
  output logic [SW-1:0]           slot
);

  typedef enum logic [1:0] {IDLE, LOAD, MUL, STORE} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] ptr;
  logic [SW-1:0] slot_inc;
  logic [7:0]    a_q;
  logic [16:0]   sreg;
  logic [2:0]    step;
  logic [8:0]    acc_sum;
  logic [7:0]    wave_sel, env_sel;
  logic [SW:0]   pick_idle, pick_next;

  // Round-robin search: {found, index} of the first enabled voice at or after start, wrapping.
  function automatic logic [SW:0] pick(input logic [SW-1:0] start, input logic [NUM_VOICES-1:0] en);
    logic [SW:0]           r;
    logic [NUM_VOICES-1:0] t;
    int                    idx;
    r = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_VOICES;
      t   = en >> idx;
      if (t[0]) r = {1'b1, SW'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    slot_inc  = SW'((int'(slot) + 1) % NUM_VOICES);
    pick_idle = pick(ptr, voice_en);
    pick_next = pick(slot_inc, voice_en);
    wave_sel  = 8'(wave_in >> (32'd8 * 32'(slot)));
    env_sel   = 8'(env_in >> (32'd8 * 32'(slot)));
    acc_sum   = sreg[16:8] + (sreg[0] ? {1'b0, a_q} : 9'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_idle[SW]) state_nx = LOAD;
      LOAD:    state_nx = MUL;
      MUL:     if (step == 3'd7) state_nx = STORE;
      STORE:   state_nx = pick_next[SW] ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
      ptr  <= '0;
      a_q  <= '0;
      sreg <= '0;
      step <= '0;
    end else begin
      case (state)
        IDLE: if (pick_idle[SW]) slot <= pick_idle[SW-1:0];
        LOAD: begin
          a_q  <= wave_sel;
          sreg <= {9'd0, env_sel};
          step <= '0;
        end
        MUL: begin
          sreg <= {1'b0, acc_sum, sreg[7:1]};
          step <= step + 3'd1;
        end
        STORE: begin
          if (pick_next[SW]) slot <= pick_next[SW-1:0];
          else               ptr  <= slot_inc;
        end
        default: ;
      endcase
    end
  end

  // Disable clears the output and wins over a store landing in the same cycle.
  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    logic [7:0] vout_r;
    logic       vld_r;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vout_r <= '0;
        vld_r  <= 1'b0;
      end else begin
        vld_r <= (state == STORE) && voice_en[i] && (slot == SW'(i));
        if (!voice_en[i])                               vout_r <= '0;
        else if ((state == STORE) && (slot == SW'(i))) vout_r <= sreg[15:8];
      end
    end
    assign voice_out[i*8 +: 8] = vout_r;
    assign out_valid[i]        = vld_r;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sid_env_mul_scheduler.sv
// tb/tb_sid_env_mul_scheduler.sv - directed self-checking bench for sid_env_mul_scheduler
module tb_sid_env_mul_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] wave_in = '0;
  logic [23:0] env_in = '0;
  logic [2:0]  voice_en = '0;
  logic [23:0] voice_out;
  logic [2:0]  out_valid;
  logic        busy;
  logic [1:0]  slot;

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  sid_env_mul_scheduler #(.NUM_VOICES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .wave_in   (wave_in),
    .env_in    (env_in),
    .voice_en  (voice_en),
    .voice_out (voice_out),
    .out_valid (out_valid),
    .busy      (busy),
    .slot      (slot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Counts edges until a strobe is seen (sampled 1ns after each edge), bounded.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (out_valid == 3'b000 && cnt < 300);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_voice_out", 32'(voice_out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_slot", 32'(slot), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // single voice
    voice_en = 3'b001;
    wave_in  = 24'h000080;
    env_in   = 24'h0000FF;
    reset_dut();
    wait_valid(n);
    check("t1_first_lat", 32'(n), 32'd11);
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_value", 32'(voice_out[7:0]), 32'h7F);
    wait_valid(n);
    check("t1_period", 32'(n), 32'd10);
    check("t1_valid2", 32'(out_valid), 32'h1);

    // three voices round-robin
    voice_en = 3'b111;
    wave_in  = {8'h00, 8'hFF, 8'h40};
    env_in   = {8'hFF, 8'hFF, 8'h80};
    reset_dut();
    wait_valid(n);
    check("t2_lat0", 32'(n), 32'd11);
    check("t2_valid0", 32'(out_valid), 32'h1);
    check("t2_out0", 32'(voice_out[7:0]), 32'h20);
    wait_valid(n);
    check("t2_lat1", 32'(n), 32'd10);
    check("t2_valid1", 32'(out_valid), 32'h2);
    check("t2_out1", 32'(voice_out[15:8]), 32'hFE);
    wait_valid(n);
    check("t2_lat2", 32'(n), 32'd10);
    check("t2_valid2", 32'(out_valid), 32'h4);
    check("t2_out2", 32'(voice_out[23:16]), 32'h00);
    wait_valid(n);
    check("t2_lat3", 32'(n), 32'd10);
    check("t2_valid3", 32'(out_valid), 32'h1);

    // skip and wrap
    voice_en = 3'b101;
    wave_in  = {8'hFF, 8'h55, 8'h10};
    env_in   = {8'h80, 8'h55, 8'h10};
    reset_dut();
    wait_valid(n);
    check("t3_lat0", 32'(n), 32'd11);
    check("t3_valid0", 32'(out_valid), 32'h1);
    check("t3_out0", 32'(voice_out[7:0]), 32'h01);
    check("t3_slot_next", 32'(slot), 32'd2);
    wait_valid(n);
    check("t3_lat2", 32'(n), 32'd10);
    check("t3_valid2", 32'(out_valid), 32'h4);
    check("t3_out2", 32'(voice_out[23:16]), 32'h7F);
    check("t3_slot_wrap", 32'(slot), 32'd0);
    wait_valid(n);
    check("t3_valid0b", 32'(out_valid), 32'h1);
    wait_valid(n);
    check("t3_valid2b", 32'(out_valid), 32'h4);
    check("t3_out1_idle", 32'(voice_out[15:8]), 32'h00);

    // inputs sampled only in LOAD
    voice_en = 3'b001;
    wave_in  = 24'h000010;
    env_in   = 24'h000010;
    reset_dut();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t4_busy", 32'(busy), 32'h1);
    wave_in = 24'h0000FF;
    env_in  = 24'h0000FF;
    wait_valid(n);
    check("t4_lat", 32'(n), 32'd9);
    check("t4_value", 32'(voice_out[7:0]), 32'h01);

    // mid-flight disable of voice 1 in its second round
    voice_en = 3'b111;
    wave_in  = {8'h00, 8'hFF, 8'h40};
    env_in   = {8'hFF, 8'hFF, 8'h80};
    reset_dut();
    repeat (4) wait_valid(n);
    check("t5_slot1", 32'(slot), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("t5_out1_before", 32'(voice_out[15:8]), 32'hFE);
    voice_en = 3'b101;
    @(posedge clk);
    #1;
    check("t5_out1_cleared", 32'(voice_out[15:8]), 32'h00);
    wait_valid(n);
    check("t5_skip_lat", 32'(n), 32'd16);
    check("t5_valid2", 32'(out_valid), 32'h4);
    check("t5_out1_stays", 32'(voice_out[15:8]), 32'h00);

    // asynchronous reset mid-MUL
    repeat (3) @(posedge clk);
    #2;
    check("t6_busy_before", 32'(busy), 32'h1);
    check("t6_out0_before", 32'(voice_out[7:0]), 32'h20);
    rst = 1'b1;
    #1;
    check("t6_async_out", 32'(voice_out), 32'h0);
    check("t6_async_valid", 32'(out_valid), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_slot", 32'(slot), 32'h0);
    voice_en = 3'b111;
    @(negedge clk);
    rst = 1'b0;
    wait_valid(n);
    check("t6_restart_lat", 32'(n), 32'd11);
    check("t6_restart_v0", 32'(out_valid), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
